// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low hex keypad one row at a time,
// debounces presses and releases on scan ticks, decodes each accepted key to
// a hex nibble and shifts it into a 16-bit word for the display driver.
//
// Output handshake: key_valid is a single-cycle strobe with no ready/back-
// pressure. On the cycle it is high, key_code holds the accepted key and
// dataout already contains it in [3:0]; both hold until the next acceptance
// (dataout also changes on clear).
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,  // clk cycles per scan tick, >= 4
  parameter int DEBOUNCE = 4       // matching ticks to accept press/release, 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cols,
  input  logic        clear,
  output logic [3:0]  rows,
  output logic [15:0] dataout,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB4     = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // state is kept as a plain named register so checkers can bind to it
  state_t        state;
  logic [1:0]    ridx;
  logic [3:0]    cnt;
  logic [3:0]    pat;
  logic [DW-1:0] div;
  logic [3:0]    sync1;
  logic [3:0]    scol;
  logic          tick;
  logic [3:0]    cnt_inc;
  logic [3:0]    acc_pat;
  logic [3:0]    code;
  logic          accept;

  // True when exactly one column is pulled low.
  function automatic logic single_low(input logic [3:0] p);
    case (p)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  // Row index plus one-low column pattern -> key nibble.
  function automatic logic [3:0] decode(input logic [1:0] r, input logic [3:0] p);
    logic [1:0] c;
    c = 2'd0;
    case (p)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: c = 2'd0;
    endcase
    case ({r, c})
      4'd0:    decode = 4'h1;
      4'd1:    decode = 4'h2;
      4'd2:    decode = 4'h3;
      4'd3:    decode = 4'hA;
      4'd4:    decode = 4'h4;
      4'd5:    decode = 4'h5;
      4'd6:    decode = 4'h6;
      4'd7:    decode = 4'hB;
      4'd8:    decode = 4'h7;
      4'd9:    decode = 4'h8;
      4'd10:   decode = 4'h9;
      4'd11:   decode = 4'hC;
      4'd12:   decode = 4'hE;
      4'd13:   decode = 4'h0;
      4'd14:   decode = 4'hF;
      default: decode = 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs (idle = all high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 4'b1111;
      scol  <= 4'b1111;
    end else begin
      sync1 <= cols;
      scol  <= sync1;
    end
  end

  // Free-running scan tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick    = (div == DIV_LAST);
  assign cnt_inc = cnt + 4'd1;

  // Acceptance decision and decoded key for the current tick.
  always_comb begin
    acc_pat = (state == SCAN) ? scol : pat;
    code    = decode(ridx, acc_pat);
    accept  = 1'b0;
    if (tick) begin
      if (state == SCAN && DEBOUNCE == 1 && single_low(scol)) begin
        accept = 1'b1;
      end
      if (state == CONFIRM && scol == pat && cnt_inc == DEB4) begin
        accept = 1'b1;
      end
    end
  end

  // Scan / confirm / release sequencer; rows tracks ridx as a rotating zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      ridx  <= 2'd0;
      rows  <= 4'b1110;
      cnt   <= 4'd0;
      pat   <= 4'b1111;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (single_low(scol)) begin
            pat <= scol;
            if (accept) begin
              cnt   <= 4'd0;
              state <= RELEASE;
            end else begin
              cnt   <= 4'd1;
              state <= CONFIRM;
            end
          end else begin
            ridx <= ridx + 2'd1;
            rows <= {rows[2:0], rows[3]};
          end
        end
        CONFIRM: begin
          if (scol == pat) begin
            if (accept) begin
              cnt   <= 4'd0;
              state <= RELEASE;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt   <= 4'd0;
            ridx  <= ridx + 2'd1;
            rows  <= {rows[2:0], rows[3]};
            state <= SCAN;
          end
        end
        RELEASE: begin
          if (scol == 4'b1111) begin
            if (cnt_inc == DEB4) begin
              cnt   <= 4'd0;
              ridx  <= ridx + 2'd1;
              rows  <= {rows[2:0], rows[3]};
              state <= SCAN;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt <= 4'd0;
          end
        end
        default: begin
          cnt   <= 4'd0;
          state <= SCAN;
        end
      endcase
    end
  end

  // Registered key outputs and the nibble shift register; clear is not tick-gated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataout   <= 16'h0000;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= code;
      end
      if (clear) begin
        dataout <= accept ? {12'h000, code} : 16'h0000;
      end else if (accept) begin
        dataout <= {dataout[11:0], code};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 keypad into keypad_scanner and
// checks every accepted key against a reference word built from the keypad
// legend and plain nibble shifting.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [15:0] dataout;
  logic [3:0]  key_code;
  logic        key_valid;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .clear    (clear),
    .rows     (rows),
    .dataout  (dataout),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  // ---------------- keypad model ----------------
  // pressed[r*4+c] closes the switch at row r, column c.
  logic [15:0] pressed;
  logic [3:0]  keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt = 0;
  logic [23:0] exp_q[$];       // {row pattern, key code, dataout}
  logic [15:0] model_data;
  logic [23:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int key_index(input logic [3:0] code);
    for (int i = 0; i < 16; i++) if (keymap[i] == code) return i;
    return 0;
  endfunction

  function automatic logic [3:0] row_pat(input int idx);
    logic [3:0] p;
    p = ~(4'b0001 << (idx / 4));
    return p;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (key_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got key_code %0h dataout %0h expected no pulse",
                 key_code, dataout);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_code", {28'd0, key_code}, {28'd0, mon_e[19:16]});
        check("pulse_data", {16'd0, dataout}, {16'd0, mon_e[15:0]});
        check("pulse_rows", {28'd0, rows}, {28'd0, mon_e[23:20]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_key(input logic [3:0] code, input logic clr);
    int idx;
    idx = key_index(code);
    model_data = clr ? {12'h000, code} : {model_data[11:0], code};
    exp_q.push_back({row_pat(idx), code, model_data});
  endtask

  task automatic press_key(input logic [3:0] code, input int hold, input int rel);
    int idx;
    idx = key_index(code);
    expect_key(code, 1'b0);
    pressed = 16'h0001 << idx;
    repeat (hold) @(negedge clk);
    check("rows_frozen", {28'd0, rows}, {28'd0, row_pat(idx)});
    pressed = 16'h0000;
    repeat (rel) @(negedge clk);
  endtask

  // Wait (bounded) for the scan to step onto the row with pattern p.
  task automatic wait_row_entry(input logic [3:0] p);
    logic [3:0] prev;
    logic       found;
    prev  = rows;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (rows == p && prev != p) found = 1'b1;
      prev = rows;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL row_wait_timeout: got rows %0h expected entry to %0h", rows, p);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_rows;
    logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4};
    logic [3:0] beef [4] = '{4'hB, 4'hE, 4'hE, 4'hF};
    int         p0;

    reset = 1'b1;
    clear = 1'b0;
    pressed = 16'h0000;
    model_data = 16'h0000;

    // Reset asserted mid-count.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rows", {28'd0, rows}, 32'h0000000E);
    check("reset_data", {16'd0, dataout}, 32'h0);
    check("reset_valid", {31'd0, key_valid}, 32'h0);
    check("reset_code", {28'd0, key_code}, 32'h0);
    reset = 1'b0;

    // Idle scanning: row advances every SD clocks.
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      exp_rows = ~(4'b0001 << ((n / SD) % 4));
      check("idle_scan_rows", {28'd0, rows}, {28'd0, exp_rows});
    end

    // Single press of "5".
    press_key(4'h5, 60, 40);

    // Clear on its own.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_data = 16'h0000;
    check("clear_alone", {16'd0, dataout}, 32'h0);

    // Sequence 1, 2, 3, A, 4.
    for (int i = 0; i < 5; i++) press_key(seq[i], 60, 40);

    // "*" glitch (1 tick present, 1 tick absent), then stable.
    pressed = 16'h0001 << key_index(4'hE);
    repeat (SD) @(negedge clk);
    pressed = 16'h0000;
    repeat (SD) @(negedge clk);
    press_key(4'hE, 60, 40);

    // Two keys in the same row: never accepted.
    p0 = pulse_cnt;
    pressed = 16'h0003;
    repeat (120) @(negedge clk);
    pressed = 16'h0000;
    repeat (20) @(negedge clk);
    check("two_key_no_pulse", pulse_cnt - p0, 32'd0);

    // Hold "#" for 50 ticks, bounce on release.
    p0 = pulse_cnt;
    expect_key(4'hF, 1'b0);
    pressed = 16'h0001 << key_index(4'hF);
    repeat (50 * SD) @(negedge clk);
    check("hold_rows", {28'd0, rows}, 32'h7);
    pressed = 16'h0000;
    repeat (SD) @(negedge clk);
    pressed = 16'h0001 << key_index(4'hF);
    repeat (SD) @(negedge clk);
    pressed = 16'h0000;
    repeat (8) @(negedge clk);
    check("release_still_held", {28'd0, rows}, 32'h7);
    repeat (12) @(negedge clk);
    check("release_exit", {31'd0, rows != 4'b0111}, 32'd1);
    check("hold_single_pulse", pulse_cnt - p0, 32'd1);
    repeat (20) @(negedge clk);

    // Build BEEF, then clear on exactly the accepting edge of "9".
    for (int i = 0; i < 4; i++) press_key(beef[i], 60, 40);
    check("beef_word", {16'd0, dataout}, 32'h0000BEEF);
    wait_row_entry(4'b1011);
    expect_key(4'h9, 1'b1);
    pressed = 16'h0001 << key_index(4'h9);
    // Detection tick is SD edges away, acceptance (DB-1)*SD edges after that.
    repeat (SD + (DB - 1) * SD - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (48) @(negedge clk);
    check("clear_accept_word", {16'd0, dataout}, 32'h00000009);
    pressed = 16'h0000;
    repeat (40) @(negedge clk);

    // Randomized keys.
    for (int i = 0; i < 12; i++) begin
      press_key(4'($urandom_range(0, 15)), $urandom_range(48, 120), $urandom_range(24, 60));
    end
    check("random_word", {16'd0, dataout}, {16'd0, model_data});

    // Reset while a press of "1" is being confirmed.
    wait_row_entry(4'b1110);
    p0 = pulse_cnt;
    pressed = 16'h0001;
    repeat (SD + 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    pressed = 16'h0000;
    model_data = 16'h0000;
    check("confirm_reset_data", {16'd0, dataout}, 32'h0);
    check("confirm_reset_code", {28'd0, key_code}, 32'h0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("confirm_reset_no_pulse", pulse_cnt - p0, 32'd0);
    check("confirm_reset_data_after", {16'd0, dataout}, 32'h0);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 matrix hex keypad, debounces key presses and decodes each press to a hex nibble.
- Accumulates the last four nibbles into a 16-bit word that feeds the 16-bit input of the seven-segment display driver.
- This is the input end of the display path: it drives keypad rows one at a time and reads columns, mirroring the display driver's one-at-a-time digit ground scanning.

## Interface

Parameters:
- SCAN_DIV, 50000: clk cycles per scan tick; must be >= 4.
- DEBOUNCE, 4: consecutive matching ticks needed to accept a press or a release; must be >= 1 and <= 15.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- cols  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
- clear  input  1  synchronous; clears dataout on the next clk edge.
- rows  output  4  keypad row drive, active-low, one-hot-low.
- dataout  output  16  last four accepted keys, newest in [3:0].
- key_code  output  4  code of the most recently accepted key.
- key_valid  output  1  one-cycle pulse per accepted key.

## Operation

- **Synchronizer:** cols passes through a 2-flop synchronizer (reset value 4'b1111). All decisions use the synchronized value scol.
- **Tick divider:** counts 0..SCAN_DIV-1 and wraps. tick = (div == SCAN_DIV-1). All state activity occurs only on tick edges, except clear and reset.
- **Row index:** ridx, 2 bits. rows = ~(4'b0001 << ridx).
- **Valid press pattern:** scol has exactly one bit low. Column index c = position of that low bit (scol[0] = column 0).
- **Key decode:** code = map[ridx][c].
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E (*), 0, F (#), D
- **State SCAN, on tick:**
  - If scol has exactly one bit low: latch pat = scol, set cnt = 1, go to CONFIRM. ridx is frozen.
  - Otherwise (no bit low, or more than one bit low): ridx = ridx + 1, wrapping 3 -> 0.
- **State CONFIRM, on tick:**
  - If scol == pat: cnt = cnt + 1.
  - When the incremented cnt reaches DEBOUNCE (or immediately if DEBOUNCE == 1 on entry): key_valid = 1, key_code = code, dataout = {dataout[11:0], code}, cnt = 0, go to RELEASE.
  - If scol != pat: cnt = 0, ridx = ridx + 1, go to SCAN.
- **State RELEASE, on tick:** ridx stays frozen.
  - If scol == 4'b1111: cnt = cnt + 1; on reaching DEBOUNCE, cnt = 0, ridx = ridx + 1, go to SCAN.
  - Otherwise cnt = 0. A held key therefore never repeats.
- **clear:** dataout = 0 on the next edge. If clear and acceptance fall on the same edge, dataout = {12'h000, code}; key_valid still pulses.
- **Mid-operation reset:** reset at any time returns all state to reset values immediately. A partially debounced key is discarded.

## Timing

- **Reset values:** rows = 4'b1110, dataout = 16'h0000, key_code = 4'h0, key_valid = 0, state SCAN, ridx = 0, div = 0, cnt = 0.
- All outputs are registered.
- **key_valid:** high for exactly one clk cycle, beginning with the tick edge that accepts the key. dataout and key_code update on that same edge.
- **Row settling:** rows changes on a tick edge; cols is next evaluated SCAN_DIV cycles later. This covers the 2-cycle synchronizer delay.
- **Acceptance latency:** the key is accepted DEBOUNCE-1 ticks after the SCAN tick that detected it, i.e. (DEBOUNCE-1)*SCAN_DIV clk cycles later.
- **Minimum cycle between two accepted keys:** DEBOUNCE ticks of release, plus scan, plus confirm.
- **dataout:** a 16-bit shift register. The oldest nibble drops off the top; there is no overflow flag.

## Test plan

Bench setup: SCAN_DIV=4, DEBOUNCE=3, keypad model pulls the column low while its row is driven low.

1. **Reset:** assert reset mid-count, hold 3 cycles -> rows=4'b1110, dataout=0, key_valid=0; with no key, rows then cycles 1110, 1101, 1011, 0111 every 4 clks.
2. **Single press:** hold key "5" (row1, col1) -> exactly one key_valid pulse, key_code=5, dataout=16'h0005, rows frozen at 4'b1101 until release. Release -> scanning resumes after 3 idle ticks.
3. **Sequence:** press and release 1, 2, 3, A, 4 -> dataout = 16'h0001, 16'h0012, 16'h0123, 16'h123A, then 16'h23A4.
4. **Bounce:** key "*" present for 1 tick, absent 1 tick, then stable -> no pulse during the glitch, one key_valid with key_code=E after 3 stable ticks. Two keys in the same row held together (cols=4'b1100) -> no key_valid ever.
5. **Hold and release bounce:** hold "#" for 50 ticks, then bounce release (1 tick open, 1 tick closed, then open) -> exactly one pulse with code F, no repeat; SCAN is re-entered only after 3 consecutive open ticks.
6. **clear coincident with acceptance:** assert clear on the accepting edge of key "9" with dataout=16'hBEEF -> dataout=16'h0009, key_valid=1. Assert reset during CONFIRM -> no pulse, dataout=0.
